// File: rtl/wbck_arb_if.sv
// Write-back channel bundle: per-channel valid/ready handshake plus the
// result data and destination index offered by each execute source.
interface wbck_arb_if #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int NCH         = 3
);
   logic [NCH-1:0]             wbck_i_valid;
   logic [NCH-1:0]             wbck_i_ready;
   logic [NCH*XLEN-1:0]        wbck_i_wdat;
   logic [NCH*RFIDX_WIDTH-1:0] wbck_i_rdidx;

   modport master (
      output wbck_i_valid,
      output wbck_i_wdat,
      output wbck_i_rdidx,
      input  wbck_i_ready
   );

   modport slave (
      input  wbck_i_valid,
      input  wbck_i_wdat,
      input  wbck_i_rdidx,
      output wbck_i_ready
   );
endinterface

// File: rtl/wbck_arb.sv
// Write-back arbiter: picks one of NCH result sources per cycle for the single
// regfile write port, with round-robin long pipes and ALU starvation guard.
module wbck_arb #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int NCH         = 3,
   parameter int STARVE_MAX  = 4,
   localparam int CHW        = $clog2(NCH),
   localparam int SW         = $clog2(STARVE_MAX + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   wbck_arb_if.slave              bus,
   input  logic                   cmt_wbck_irqexcp,
   output logic                   wbck_o_rf_ena,
   output logic [XLEN-1:0]        wbck_o_rf_wdat,
   output logic [RFIDX_WIDTH-1:0] wbck_o_rf_rdidx,
   output logic [CHW-1:0]         wbck_o_ch
);

   logic [CHW-1:0]         ptr;
   logic [SW-1:0]          starve_cnt;
   logic [NCH-1:0]         grant;
   logic [CHW-1:0]         gnt_idx;
   logic                   gnt_any;
   logic                   found;
   logic [CHW-1:0]         lp_idx;
   logic [CHW:0]           cand_sum;
   logic [CHW-1:0]         cand;
   logic                   starved;
   logic                   kill;
   logic [XLEN-1:0]        sel_wdat;
   logic [RFIDX_WIDTH-1:0] sel_rdidx;

   assign starved = bus.wbck_i_valid[0] && (starve_cnt == SW'(STARVE_MAX));

   // Long-pipe search walks ptr..NCH-1 then wraps to 1, never visiting channel 0.
   always_comb begin
      found    = 1'b0;
      lp_idx   = '0;
      cand_sum = '0;
      cand     = '0;
      for (int i = 0; i < NCH - 1; i++) begin
         cand_sum = {1'b0, ptr} + (CHW+1)'(i);
         if (cand_sum >= (CHW+1)'(NCH)) begin
            cand_sum = cand_sum - (CHW+1)'(NCH - 1);
         end
         cand = CHW'(cand_sum);
         if (!found && bus.wbck_i_valid[cand]) begin
            found  = 1'b1;
            lp_idx = cand;
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (starved) begin
         gnt_any = 1'b1;
      end else if (found) begin
         gnt_idx = lp_idx;
         gnt_any = 1'b1;
      end else if (bus.wbck_i_valid[0]) begin
         gnt_any = 1'b1;
      end
      grant = gnt_any ? (NCH'(1) << gnt_idx) : '0;
   end

   assign bus.wbck_i_ready = grant;
   assign sel_wdat  = bus.wbck_i_wdat[gnt_idx*XLEN +: XLEN];
   assign sel_rdidx = bus.wbck_i_rdidx[gnt_idx*RFIDX_WIDTH +: RFIDX_WIDTH];
   assign kill      = grant[0] & cmt_wbck_irqexcp;

   // Fairness state: ALU grants leave the long-pipe rotation untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= CHW'(1);
         starve_cnt <= '0;
      end else begin
         if (gnt_any && (gnt_idx != '0)) begin
            ptr <= (gnt_idx == CHW'(NCH - 1)) ? CHW'(1) : gnt_idx + CHW'(1);
         end
         if (!bus.wbck_i_valid[0] || grant[0]) begin
            starve_cnt <= '0;
         end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end
   end

   // Killed and x0 writes are still consumed upstream; only the enable drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbck_o_rf_ena   <= 1'b0;
         wbck_o_rf_wdat  <= '0;
         wbck_o_rf_rdidx <= '0;
         wbck_o_ch       <= '0;
      end else begin
         wbck_o_rf_ena <= gnt_any & ~kill & (sel_rdidx != '0);
         if (gnt_any) begin
            wbck_o_rf_wdat  <= sel_wdat;
            wbck_o_rf_rdidx <= sel_rdidx;
            wbck_o_ch       <= gnt_idx;
         end
      end
   end

endmodule
